// File: rtl/vga_pkg.sv
// Purpose: shared VGA raster timing constants and coordinate/colour types for
// the display output path. Defaults describe 640x480@60 Hz driven from a
// 50 MHz clock with a divide-by-two pixel strobe.
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    // Vertical timing, in lines
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 8;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/mod_counter.sv
// Purpose: modulo-N up counter with enable and synchronous clear.
// Ports:
//   clock  - counter clock
//   clear  - synchronous clear to zero, overrides en
//   en     - advance by one when high
//   count  - current value, 0..MODULUS-1
//   wrap   - high in the enabled cycle that takes count from MODULUS-1 to 0
module mod_counter #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned MODULUS = 800
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign wrap = en && (count == LAST);

    // Count register; wraps to zero rather than overflowing past LAST
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_timing_out.sv
// Purpose: VGA raster generator and pin-side output register. Produces the
// row/col coordinates for the renderer, then registers the returned colour
// with matching sync/blank one pixel period later.
// Ports:
//   clock, reset            - system clock, synchronous active-high reset
//   red_in/green_in/blue_in - renderer colour for the current row/col
//   row, col                - raster position (combinational from counters)
//   blank                   - position is outside the visible area
//   pix_en                  - pixel strobe, high every second clock
//   frame_done              - one-clock pulse on the last pixel of a frame
//   VGA_R/G/B               - registered colour, forced to 0 while blanked
//   VGA_HS_L/VGA_VS_L       - registered syncs, active low
//   VGA_BLANK_L             - registered blank, active low
// Timing parameters default to the package values; they may be overridden to
// build a smaller raster with the same structure.
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS = H_VISIBLE,
    parameter int unsigned H_FP  = H_FRONT,
    parameter int unsigned H_SW  = H_SYNC,
    parameter int unsigned H_BP  = H_BACK,
    parameter int unsigned V_VIS = V_VISIBLE,
    parameter int unsigned V_FP  = V_FRONT,
    parameter int unsigned V_SW  = V_SYNC,
    parameter int unsigned V_BP  = V_BACK
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    output coord_t             row,
    output coord_t             col,
    output logic               blank,
    output logic               pix_en,
    output logic               frame_done,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS_L,
    output logic               VGA_VS_L,
    output logic               VGA_BLANK_L
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SW + V_BP;

    localparam coord_t H_VIS_C  = COORD_W'(H_VIS);
    localparam coord_t V_VIS_C  = COORD_W'(V_VIS);
    localparam coord_t HS_FIRST = COORD_W'(H_VIS + H_FP);
    localparam coord_t HS_LAST  = COORD_W'(H_VIS + H_FP + H_SW - 1);
    localparam coord_t VS_FIRST = COORD_W'(V_VIS + V_FP);
    localparam coord_t VS_LAST  = COORD_W'(V_VIS + V_FP + V_SW - 1);

    logic   phase;
    coord_t h_count;
    coord_t v_count;
    logic   h_wrap;
    logic   v_wrap;
    logic   hs;
    logic   vs;
    rgb_t   rgb_in;

    // Divide-by-two pixel strobe; reset leaves it low so the first strobe
    // lands on the second clock after release
    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    assign pix_en = phase;

    mod_counter #(
        .WIDTH   (COORD_W),
        .MODULUS (H_TOT)
    ) u_h_counter (
        .clock (clock),
        .clear (reset),
        .en    (phase),
        .count (h_count),
        .wrap  (h_wrap)
    );

    // Line counter steps once per horizontal wrap
    mod_counter #(
        .WIDTH   (COORD_W),
        .MODULUS (V_TOT)
    ) u_v_counter (
        .clock (clock),
        .clear (reset),
        .en    (phase & h_wrap),
        .count (v_count),
        .wrap  (v_wrap)
    );

    assign row        = v_count;
    assign col        = h_count;
    assign blank      = (h_count >= H_VIS_C) || (v_count >= V_VIS_C);
    assign hs         = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
    assign vs         = (v_count >= VS_FIRST) && (v_count <= VS_LAST);
    // Vertical wrap only fires on the strobe at the last pixel of the frame
    assign frame_done = v_wrap;

    assign rgb_in = '{r: red_in, g: green_in, b: blue_in};

    // Pin register: colour, syncs and blank share one stage so they stay aligned
    always_ff @(posedge clock) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS_L    <= 1'b1;
            VGA_VS_L    <= 1'b1;
            VGA_BLANK_L <= 1'b0;
        end else if (phase) begin
            VGA_R       <= blank ? '0 : rgb_in.r;
            VGA_G       <= blank ? '0 : rgb_in.g;
            VGA_B       <= blank ? '0 : rgb_in.b;
            VGA_HS_L    <= ~hs;
            VGA_VS_L    <= ~vs;
            VGA_BLANK_L <= ~blank;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Purpose: self-checking bench for vga_timing_out. Full-width lines, shortened
// frame height so several frames fit in a short run. A pixel-index model
// (clocks since release -> pixel number -> row/col) predicts every output.
module tb_vga_timing_out;

    localparam int unsigned H_VIS = 640;
    localparam int unsigned H_FP  = 16;
    localparam int unsigned H_SW  = 96;
    localparam int unsigned H_BP  = 48;
    localparam int unsigned V_VIS = 6;
    localparam int unsigned V_FP  = 1;
    localparam int unsigned V_SW  = 2;
    localparam int unsigned V_BP  = 2;

    localparam int unsigned H_TOT     = H_VIS + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOT     = V_VIS + V_FP + V_SW + V_BP;
    localparam int unsigned FRAME_PIX = H_TOT * V_TOT;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] red_in, green_in, blue_in;
    logic [9:0] row, col;
    logic       blank, pix_en, frame_done;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS_L, VGA_VS_L, VGA_BLANK_L;

    vga_timing_out #(
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SW (H_SW), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SW (V_SW), .V_BP (V_BP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .row         (row),
        .col         (col),
        .blank       (blank),
        .pix_en      (pix_en),
        .frame_done  (frame_done),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS_L    (VGA_HS_L),
        .VGA_VS_L    (VGA_VS_L),
        .VGA_BLANK_L (VGA_BLANK_L)
    );

    always #10 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_blank(input int unsigned r, input int unsigned c);
        return (c >= H_VIS) || (r >= V_VIS);
    endfunction

    function automatic bit in_hs(input int unsigned c);
        return (c >= H_VIS + H_FP) && (c < H_VIS + H_FP + H_SW);
    endfunction

    function automatic bit in_vs(input int unsigned r);
        return (r >= V_VIS + V_FP) && (r < V_VIS + V_FP + V_SW);
    endfunction

    // Model state: k = clock edges since reset released (0 right after a reset edge)
    int unsigned k = 0;
    int unsigned tclk = 0;
    logic [7:0]  e_r = 8'h00, e_g = 8'h00, e_b = 8'h00;
    logic        e_hs_l = 1'b1, e_vs_l = 1'b1, e_blank_l = 1'b0;
    bit          const_mode = 1'b1;
    bit          line_meas = 1'b1;
    bit          fd_first_pending = 1'b1;
    bit          have_last_fd = 1'b0;
    int unsigned last_fd_t = 0;
    int unsigned vs_low_cnt = 0;
    int unsigned fd_seen = 0;
    int unsigned ff_cnt = 0;
    int unsigned hs_low_cnt = 0;

    // One clock: update the model across the edge, then compare at the falling edge
    task automatic tick();
        bit          was_reset;
        int unsigned p, r, c;
        was_reset = reset;
        @(posedge clock);
        #1;
        tclk++;
        if (was_reset) begin
            k = 0;
            e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
            e_hs_l = 1'b1; e_vs_l = 1'b1; e_blank_l = 1'b0;
            fd_first_pending = 1'b1;
            have_last_fd = 1'b0;
            vs_low_cnt = 0;
        end else begin
            if (k % 2 == 1) begin
                // Strobe edge: pins take the pixel the counters are leaving
                p = (k / 2) % FRAME_PIX;
                r = p / H_TOT;
                c = p % H_TOT;
                e_r       = in_blank(r, c) ? 8'h00 : red_in;
                e_g       = in_blank(r, c) ? 8'h00 : green_in;
                e_b       = in_blank(r, c) ? 8'h00 : blue_in;
                e_hs_l    = ~in_hs(c);
                e_vs_l    = ~in_vs(r);
                e_blank_l = ~in_blank(r, c);
            end
            k++;
        end
        if (!const_mode && (k % 2 == 0)) begin
            red_in   = 8'($urandom);
            green_in = 8'($urandom);
            blue_in  = 8'($urandom);
        end
        @(negedge clock);
        p = (k / 2) % FRAME_PIX;
        r = p / H_TOT;
        c = p % H_TOT;
        check("row", 32'(row), r);
        check("col", 32'(col), c);
        check("pix_en", 32'(pix_en), 32'(k % 2));
        check("blank", 32'(blank), 32'(in_blank(r, c)));
        check("frame_done", 32'(frame_done), 32'((k % 2 == 1) && (p == FRAME_PIX - 1)));
        check("rgb", {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, e_r, e_g, e_b});
        check("hs_l", 32'(VGA_HS_L), 32'(e_hs_l));
        check("vs_l", 32'(VGA_VS_L), 32'(e_vs_l));
        check("blank_l", 32'(VGA_BLANK_L), 32'(e_blank_l));
        if (!was_reset && (k > 0) && (k % 2 == 0)) begin
            if (!VGA_VS_L) vs_low_cnt++;
            if (line_meas && (k <= 2 * H_TOT)) begin
                if (VGA_R == 8'hFF) ff_cnt++;
                if (!VGA_HS_L) hs_low_cnt++;
            end
        end
        if (frame_done === 1'b1) begin
            fd_seen++;
            if (fd_first_pending) begin
                check("fd_after_release", k + 1, 2 * FRAME_PIX);
                fd_first_pending = 1'b0;
            end
            if (have_last_fd) check("fd_interval", tclk - last_fd_t, 2 * FRAME_PIX);
            check("vs_low_pixels", vs_low_cnt, V_SW * H_TOT);
            vs_low_cnt = 0;
            last_fd_t = tclk;
            have_last_fd = 1'b1;
        end
    endtask

    initial begin
        int unsigned target;
        int unsigned budget;
        reset    = 1'b1;
        red_in   = 8'hFF;
        green_in = 8'h00;
        blue_in  = 8'h80;
        repeat (3) tick();

        // Reset state before the first released edge
        reset = 1'b0;
        check("rst_pix_en", 32'(pix_en), 0);
        check("rst_row", 32'(row), 0);
        check("rst_col", 32'(col), 0);
        check("rst_hs_l", 32'(VGA_HS_L), 1);
        check("rst_vs_l", 32'(VGA_VS_L), 1);
        check("rst_r", 32'(VGA_R), 0);
        check("rst_fd", 32'(frame_done), 0);

        tick();
        check("clk2_pix_en", 32'(pix_en), 1);
        check("clk2_col", 32'(col), 0);
        check("clk2_r", 32'(VGA_R), 0);
        tick();
        check("clk3_col", 32'(col), 1);
        check("first_ff", 32'(VGA_R), 32'hFF);
        check("first_b", 32'(VGA_B), 32'h80);

        // Rest of the first line with constant colour
        while (k < 2 * H_TOT + 4) tick();
        check("line_ff_pixels", ff_cnt, H_VIS);
        check("line_hs_low_pixels", hs_low_cnt, H_SW);
        line_meas  = 1'b0;
        const_mode = 1'b0;

        // Random colour across two full frames
        budget = 0;
        while (fd_seen < 2 && budget < 4 * FRAME_PIX + 100) begin
            tick();
            budget++;
        end
        check("two_frames_seen", fd_seen, 2);

        // Reset in the middle of a frame while the strobe is high
        target = 5 * H_TOT + 400;
        budget = 0;
        while (!((k % 2 == 1) && ((k / 2) % FRAME_PIX == target)) && budget < 2 * FRAME_PIX + 10) begin
            tick();
            budget++;
        end
        check("mid_reset_reached", 32'(pix_en), 1);
        check("mid_reset_row", 32'(row), 5);
        check("mid_reset_col", 32'(col), 400);
        reset = 1'b1;
        tick();
        check("mid_rst_row", 32'(row), 0);
        check("mid_rst_col", 32'(col), 0);
        check("mid_rst_hs_l", 32'(VGA_HS_L), 1);
        check("mid_rst_fd", 32'(frame_done), 0);
        reset = 1'b0;

        // First frame after release must be a whole frame long
        fd_seen = 0;
        budget = 0;
        while (fd_seen < 1 && budget < 2 * FRAME_PIX + 10) begin
            tick();
            budget++;
        end
        check("post_reset_frame_seen", fd_seen, 1);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
# vga_timing_out

Display-side end of the pixel pipeline: generates the 640x480@60 Hz VGA raster from the 50 MHz system clock, drives the `row`/`col` coordinates consumed by the pixel-to-color renderer, and registers the renderer's returned RGB together with delay-matched, active-low HSYNC/VSYNC onto the VGA pins. It also emits a once-per-frame pulse that game logic uses to advance bird and pipe positions between frames.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16; H_SYNC, 96; H_BACK, 48; line total 800 pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10; V_SYNC, 2; V_BACK, 33; frame total 525 lines
- clock  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high
- red_in, green_in, blue_in  in  8 each  renderer colour for the current `row`/`col`, combinational from them
- row  out  10  current line, 0..524
- col  out  10  current pixel in line, 0..799
- blank  out  1  high when col >= 640 or row >= 480
- pix_en  out  1  one-cycle pixel strobe, every second clock
- frame_done  out  1  one-clock pulse at end of frame
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour
- VGA_HS_L, VGA_VS_L  out  1 each  registered sync, active low
- VGA_BLANK_L  out  1  registered blank, active low

## Operation
- Phase flop toggles every clock; `pix_en` = phase. Reset forces phase 0, so the first `pix_en` occurs on the second clock after reset deasserts.
- Horizontal counter `col`: advances on `pix_en`; wraps 799 -> 0. On that wrap, vertical counter `row` advances; wraps 524 -> 0.
- `row`, `col`, `blank`: combinational from the counters. Valid for the full two-clock pixel period. The renderer must settle within this period.
- Raw sync:
  - hs = (656 <= col <= 751)
  - vs = (490 <= row <= 491)
- Output stage, updated only on `pix_en`:
  - VGA_R/G/B <= blank ? 0 : *_in
  - VGA_HS_L <= ~hs
  - VGA_VS_L <= ~vs
  - VGA_BLANK_L <= ~blank
- `frame_done` = `pix_en` && col==799 && row==524. High for exactly one clock.
- Reset values:
  - counters 0, phase 0, frame_done 0
  - VGA_R/G/B = 0
  - VGA_HS_L = VGA_VS_L = 1
  - VGA_BLANK_L = 0
- Reset mid-frame: every register returns to its reset value on the next edge. No partial-line completion. Raster restarts at (0,0).
- Simultaneous wraps at (799,524): both counters go to 0 on the same `pix_en`. `frame_done` is asserted in that cycle.
- All comparisons are unsigned 10-bit; no counter value exceeds 799.

## Timing
- Latency from coordinate to pins: one pixel period (2 clocks). Pin outputs for pixel (r,c) appear on the `pix_en` edge that moves the counters off (r,c).
- Sync and blank go through the same register stage as colour, so alignment is exact.
- Line period: 800 pix_en = 1600 clocks.
- Frame period: 420,000 pix_en = 840,000 clocks (59.52 Hz).
- HS_L low for 96 pixels per line. VS_L low for 2 lines = 1600 pixels.

## Structure
- Package `vga_pkg` holds:
  - the eight timing constants
  - derived localparams H_TOTAL=800, V_TOTAL=525, HS_START=656, VS_START=490
  - the 10-bit coordinate typedef
- Sub-module `mod_counter`: parameterised width and modulus, with en, clear, and wrap output. Instantiate twice:
  - horizontal: en=pix_en
  - vertical: en=pix_en & h_wrap
- Top holds the phase flop, sync decode, and output register stage.

## Test plan
- Reset, then release:
  - clock 1: pix_en=0, row=col=0, VGA_HS_L=VGA_VS_L=1, VGA_R=0
  - clock 2: pix_en=1
  - col reaches 1 after the second clock edge.
- Constant input 0xFF/0x00/0x80 over a full line:
  - VGA_R=FF for exactly 640 consecutive pixel periods, then 0 for 160
  - first FF appears 2 clocks after col=0.
- Horizontal sync: VGA_HS_L falls on the pix_en edge leaving col=656 and rises on the pix_en edge leaving col=752. That is 96 pixel periods (192 clocks) low.
- Frame length: count clocks between consecutive `frame_done` pulses = 840,000. Each pulse is 1 clock wide and coincides with row=524, col=799.
- Vertical sync: VGA_VS_L is low for 1600 pixel periods, beginning at the output of (490,0).
- Reset at (300,400) with pix_en high:
  - next edge: row=col=0, VGA_HS_L=1
  - no `frame_done` pulse
  - next frame_done occurs exactly 840,000 clocks after reset deasserts.
